fun_driver: RTL
===============

Name: fun_driver

Overview:
Initiator for the start/busy compute-unit handshake used by `fun` (result = a * cbrt(b), 11-bit). It accepts operand pairs on a valid/ready input stream and buffers them in a small FIFO. It issues each pair to the unit with a one-cycle start pulse, waits for busy to rise and then fall, captures the result, and presents it with the echoed operands on a valid/ready output stream. It sits between a host/stream source and a `fun` instance so the unit can be fed back-to-back without host-side sequencing.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, >= 2)
A_W, 8, width of operand a
B_W, 8, width of operand b
R_W, 11, width of unit result
TIMEOUT, 255, max cycles in ACK+RUN before abort (used only with FUN_DRV_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept (= !full)
in_a  in  A_W  operand a
in_b  in  B_W  operand b
unit_start  out  1  one-cycle start pulse to compute unit
unit_a  out  A_W  operand a to unit, held stable from START until return to IDLE
unit_b  out  B_W  operand b to unit, held stable from START until return to IDLE
unit_busy  in  1  unit busy
unit_result  in  R_W  unit result, valid once busy has fallen
out_valid  out  1  result slot full
out_ready  in  1  consumer accepts result
out_result  out  R_W  captured result
out_a  out  A_W  echoed operand a
out_b  out  B_W  echoed operand b
idle  out  1  FSM in IDLE, FIFO empty and out_valid=0
err  out  1  sticky timeout flag (tied 0 without macro)

Behaviour:
- Reset (sync, rst=1 at an edge): FIFO pointers/count=0; FSM=IDLE; unit_start=0; unit_a/b=0; out_valid=0; out_result/out_a/out_b=0; err=0; idle=1 after the edge. Reset mid-transaction abandons the job; the unit is not informed.
- FIFO:
  - Push on in_valid&in_ready.
  - in_ready=0 when count==DEPTH; no bypass, so push while full is ignored.
  - Pop only by the FSM in IDLE.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, START, ACK, RUN; all registered:
  - IDLE: if FIFO non-empty and (!out_valid || out_ready), pop head into operand registers and go to START. Otherwise stay.
  - START: unit_start=1 for exactly this cycle, then go to ACK.
  - ACK: wait for unit_busy=1, then go to RUN.
  - RUN: when unit_busy=0, capture unit_result plus operands into the out slot, set out_valid=1, go to IDLE.
- unit_start is combinational from state==START and is never high outside START.
- Output slot:
  - out_valid clears on out_valid&out_ready unless a capture happens on the same edge; in that case the new result wins and out_valid stays 1.
  - Issue requires the slot free, or being freed, at issue time. Only one job is in flight, so a capture never overwrites an unread result.
- Latency (empty FIFO, FSM IDLE, out free), with in handshake in cycle c:
  - pop in c+1;
  - unit_start in c+2;
  - `fun` busy from c+3;
  - out_valid the cycle after busy is sampled low.
  - Back-to-back jobs: next unit_start 2 cycles after capture.
- Ordering: results leave in input order.
- Widths: no arithmetic on data. Operands and result pass through unmodified.
- idle is combinational.

Optional Feature:
FUN_DRV_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on entry to ACK and increments each cycle in ACK or RUN.
  - If it reaches TIMEOUT, the FSM returns to IDLE, the job is dropped (no out_valid) and err is set.
  - err is sticky until rst.
- Not defined: no counter, the FSM waits indefinitely, and err is constant 0.

Test Plan:
1. Reset, then single push a=5, b=27 into a real `fun` -> unit_start exactly one cycle at c+2; out_valid with out_result=15, out_a=5, out_b=27; idle=1 afterwards.
2. Push 4 pairs back-to-back: (255,255), (3,8), (0,200), (7,1) -> in_ready low only when 4 entries are held; results 1530, 6, 0, 7 in order.
3. Hold out_ready=0 with 3 pairs queued -> first result held stable, no second unit_start. Release out_ready -> next unit_start follows; no result lost or duplicated.
4. Assert rst during RUN of job (9,64) with 2 entries queued -> after the edge out_valid=0, in_ready=1, idle=1, unit_start never pulses until a new push.
5. Push when full and pop in the same cycle (out_ready=1, FIFO count 4 at issue) -> the push is rejected (in_ready=0), count goes to 3, and the next push is accepted.
6. With FUN_DRV_TIMEOUT_EN, TIMEOUT=20, and a stub unit holding busy=1 forever -> err=1 at cycle 20 of ACK+RUN, no out_valid, FSM back to IDLE and issuing the next job.

Source files
------------

// File: rtl/fun_driver_if.sv
// fun_driver_if: bundle of the operand stream, the start/busy unit port and
// the result stream seen by fun_driver.
//
// Stream handshake: a transfer happens on every rising clock edge where
// valid and ready are both 1. A source keeps valid and its data stable
// until that edge; ready may change freely and never depends on a later
// transfer. The unit port uses start/busy: start is a one-cycle pulse,
// busy rises afterwards, and result is valid once busy has fallen.
//
// dbg_state exposes the driver FSM state (0 IDLE, 1 START, 2 ACK, 3 RUN).
interface fun_driver_if #(
  parameter int A_W = 8,
  parameter int B_W = 8,
  parameter int R_W = 11
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;

  logic           unit_start;
  logic [A_W-1:0] unit_a;
  logic [B_W-1:0] unit_b;
  logic           unit_busy;
  logic [R_W-1:0] unit_result;

  logic           out_valid;
  logic           out_ready;
  logic [R_W-1:0] out_result;
  logic [A_W-1:0] out_a;
  logic [B_W-1:0] out_b;

  logic           idle;
  logic           err;
  logic [1:0]     dbg_state;

  // Driver side.
  modport master (
    input  in_valid, in_a, in_b, unit_busy, unit_result, out_ready,
    output in_ready, unit_start, unit_a, unit_b,
           out_valid, out_result, out_a, out_b, idle, err, dbg_state
  );

  // Environment side: stream source, compute unit and result consumer.
  modport slave (
    output in_valid, in_a, in_b, unit_busy, unit_result, out_ready,
    input  in_ready, unit_start, unit_a, unit_b,
           out_valid, out_result, out_a, out_b, idle, err, dbg_state
  );
endinterface

// File: rtl/fun_driver.sv
// fun_driver: feeds operand pairs from a small FIFO to a start/busy compute
// unit (fun: result = a * cbrt(b)) one job at a time, and returns each
// result with its operands on an output stream, in input order.
//
// Optional macro FUN_DRV_TIMEOUT_EN: when defined, a job that spends
// TIMEOUT cycles in ACK+RUN is dropped and the sticky err flag is set.
// When undefined, the FSM waits indefinitely and err is tied to 0.
module fun_driver #(
  parameter int DEPTH   = 4,
  parameter int A_W     = 8,
  parameter int B_W     = 8,
  parameter int R_W     = 11,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  fun_driver_if.master  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_ACK   = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t state;

  // Operand FIFO.
  logic [A_W-1:0]   mem_a [DEPTH];
  logic [B_W-1:0]   mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  // Operands held for the unit and the output slot.
  logic [A_W-1:0] op_a;
  logic [B_W-1:0] op_b;
  logic           out_valid_q;
  logic [R_W-1:0] out_result_q;
  logic [A_W-1:0] out_a_q;
  logic [B_W-1:0] out_b_q;

  logic capture;
  logic abort;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));

  // No bypass: a push while full is simply not accepted.
  assign push = bus.in_valid && !fifo_full;

  // Issue only when the slot is free or being freed on this same edge, so a
  // capture can never overwrite an unread result.
  assign pop = (state == S_IDLE) && !fifo_empty &&
               (!out_valid_q || bus.out_ready);

  // The unit has finished once busy is seen low after it was seen high.
  assign capture = (state == S_RUN) && !bus.unit_busy;

`ifdef FUN_DRV_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [TO_W-1:0] tmo_cnt;
  logic            err_q;

  // A finishing job in RUN takes priority over the timeout on the same edge.
  assign abort = ((state == S_ACK) || (state == S_RUN)) &&
                 (tmo_cnt == TO_W'(TIMEOUT - 1)) && !capture;

  // Cycle counter: cleared on the way into ACK, counts every ACK/RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == S_START) begin
      tmo_cnt <= '0;
    end else if ((state == S_ACK) || (state == S_RUN)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_cfg;

  assign abort      = 1'b0;
  assign bus.err    = 1'b0;
  assign unused_cfg = ^TIMEOUT;
`endif

  // FIFO storage write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Job sequencer: pop, pulse start, wait for busy high, then for busy low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            op_a  <= mem_a[rd_ptr];
            op_b  <= mem_b[rd_ptr];
            state <= S_START;
          end
        end
        S_START: begin
          state <= S_ACK;
        end
        S_ACK: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (bus.unit_busy) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (capture || abort) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output slot: a capture wins over a same-edge read by the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_a_q      <= '0;
      out_b_q      <= '0;
    end else if (capture) begin
      out_valid_q  <= 1'b1;
      out_result_q <= bus.unit_result;
      out_a_q      <= op_a;
      out_b_q      <= op_b;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.unit_start = (state == S_START);
  assign bus.unit_a     = op_a;
  assign bus.unit_b     = op_b;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_a      = out_a_q;
  assign bus.out_b      = out_b_q;
  assign bus.idle       = (state == S_IDLE) && fifo_empty && !out_valid_q;
  assign bus.dbg_state  = state;

endmodule
